// File: rtl/fractal_pkg.sv
// rtl/fractal_pkg.sv - shared widths, fixed-point types and helpers for the fractal renderer
//
// Purpose: common constants, the Q4.23 fixed-point type, the view window
// struct passed to every solver core, and the column-groups-per-solver helper.
package fractal_pkg;

  localparam int FIX_W  = 27;
  localparam int FRAC   = 23;
  localparam int CNT_W  = 8;
  localparam int ID_W   = 6;
  localparam int ADDR_W = 19;

  // Escape radius squared (4.0) on the Q.46 scale of a full product.
  localparam logic signed [2*FIX_W:0] FOUR = 55'sd4 <<< 46;

  typedef logic signed [FIX_W-1:0] fix_t;

  // Complex-plane window: origin of pixel (0,0) and per-pixel steps.
  typedef struct packed {
    fix_t min_x;
    fix_t min_y;
    fix_t dx;
    fix_t dy;
  } view_t;

  // Column groups owned by each solver: ceil(cols / solvers).
  function automatic int calc_cps(input int cols, input int solvers);
    return (cols + solvers - 1) / solvers;
  endfunction

endpackage

// File: rtl/fractal_engine_solver.sv
// rtl/fractal_engine_solver.sv - one column-interleaved Mandelbrot worker with private result RAM
//
// Purpose: walks columns SOLVER_ID, SOLVER_ID+N, ... of every row, iterates
// z = z^2 + c once per cycle, and writes each pixel's count into its RAM.
// Ports:
//   clock, reset   single clock, synchronous active-high reset
//   view           window origin/steps, captured while reset is high
//   rd_addr        read address (registered read port)
//   finished       sticky: every pixel of this core has been written
//   rd_data        RAM[rd_addr] one cycle later
module mandel_solver_core
  import fractal_pkg::*;
#(
  parameter int SOLVER_ID   = 0,
  parameter int NUM_SOLVERS = 7,
  parameter int NUM_COLUMNS = 99,
  parameter int NUM_ROWS    = 66,
  parameter int MAX_ITER    = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  view_t             view,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              finished,
  output logic [CNT_W-1:0]  rd_data
);

  localparam int CPS   = calc_cps(NUM_COLUMNS, NUM_SOLVERS);
  localparam int DEPTH = NUM_ROWS * CPS;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit HAS_WORK = (SOLVER_ID < NUM_COLUMNS);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);

  logic [CNT_W-1:0] mem [2**AW];

  fix_t cx, cy, cx_row, step_x, step_y;
  fix_t zx, zy;
  logic [CNT_W-1:0]  n;
  logic [ADDR_W-1:0] col, row;
  logic [AW-1:0]     addr, row_base;

  logic signed [2*FIX_W-1:0] zx2, zy2, zxy;
  logic signed [2*FIX_W:0]   mag;
  fix_t zx_next, zy_next;
  logic [ADDR_W-1:0] col_next;
  logic stop, last_col, last_row;

  assign zx2 = 54'(zx) * 54'(zx);
  assign zy2 = 54'(zy) * 54'(zy);
  assign zxy = 54'(zx) * 54'(zy);
  assign mag = 55'(zx2) + 55'(zy2);

  // Truncated Q4.23 products; the doubling of zx*zy is a shift of the
  // truncated product, and all sums wrap at 27 bits.
  assign zx_next = zx2[FRAC+FIX_W-1:FRAC] - zy2[FRAC+FIX_W-1:FRAC] + cx;
  assign zy_next = {zxy[FRAC+FIX_W-2:FRAC], 1'b0} + cy;

  // The iteration cap is checked before escape; either way the stored
  // result equals the current n.
  assign stop = (n == MAX_CNT) || (mag > FOUR);

  assign col_next = col + ADDR_W'(NUM_SOLVERS);
  assign last_col = (col_next >= ADDR_W'(NUM_COLUMNS));
  assign last_row = (row == ADDR_W'(NUM_ROWS - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      cx       <= view.min_x + fix_t'(view.dx * SOLVER_ID);
      cx_row   <= view.min_x + fix_t'(view.dx * SOLVER_ID);
      cy       <= view.min_y;
      step_x   <= fix_t'(view.dx * NUM_SOLVERS);
      step_y   <= view.dy;
      zx       <= '0;
      zy       <= '0;
      n        <= '0;
      col      <= ADDR_W'(SOLVER_ID);
      row      <= '0;
      addr     <= '0;
      row_base <= '0;
      finished <= !HAS_WORK;
    end else if (!finished) begin
      if (stop) begin
        zx <= '0;
        zy <= '0;
        n  <= '0;
        if (!last_col) begin
          col  <= col_next;
          addr <= addr + 1'b1;
          cx   <= cx + step_x;
        end else if (!last_row) begin
          row      <= row + 1'b1;
          col      <= ADDR_W'(SOLVER_ID);
          row_base <= row_base + AW'(CPS);
          addr     <= row_base + AW'(CPS);
          cx       <= cx_row;
          cy       <= cy + step_y;
        end else begin
          finished <= 1'b1;
        end
      end else begin
        zx <= zx_next;
        zy <= zy_next;
        n  <= n + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && !finished && stop) begin
      mem[addr] <= n;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= (rd_addr < ADDR_W'(DEPTH)) ? mem[rd_addr[AW-1:0]] : '0;
    end
  end

endmodule

// File: rtl/fractal_engine.sv
// rtl/fractal_engine.sv - parallel Mandelbrot renderer with raster-order readout
//
// Purpose: NUM_SOLVERS solver cores render one frame by column interleave;
// once all finish, a read iterator streams the frame in raster order.
// Ports:
//   clock, reset                 single clock, synchronous active-high reset
//   min_x, min_y, dx, dy         Q4.23 window, captured while reset is high
//   done                         all cores finished (sticky until reset)
//   rd_solver_id, rd_addr        iterator position (core, address in core)
//   rd_data_out                  count for the position shown 2 cycles earlier
//   end_stream                   last pixel position is being shown (sticky)
module fractal_engine
  import fractal_pkg::*;
#(
  parameter int NUM_SOLVERS = 7,
  parameter int NUM_COLUMNS = 99,
  parameter int NUM_ROWS    = 66,
  parameter int MAX_ITER    = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [FIX_W-1:0]  min_x,
  input  logic [FIX_W-1:0]  min_y,
  input  logic [FIX_W-1:0]  dx,
  input  logic [FIX_W-1:0]  dy,
  output logic              done,
  output logic [ID_W-1:0]   rd_solver_id,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [CNT_W-1:0]  rd_data_out,
  output logic              end_stream
);

  localparam int CPS = calc_cps(NUM_COLUMNS, NUM_SOLVERS);

  view_t view;
  logic [NUM_SOLVERS-1:0] finished;
  logic [CNT_W-1:0] core_data [NUM_SOLVERS];

  assign view = {min_x, min_y, dx, dy};

  for (genvar k = 0; k < NUM_SOLVERS; k++) begin : g_core
    mandel_solver_core #(
      .SOLVER_ID  (k),
      .NUM_SOLVERS(NUM_SOLVERS),
      .NUM_COLUMNS(NUM_COLUMNS),
      .NUM_ROWS   (NUM_ROWS),
      .MAX_ITER   (MAX_ITER)
    ) u_core (
      .clock   (clock),
      .reset   (reset),
      .view    (view),
      .rd_addr (rd_addr),
      .finished(finished[k]),
      .rd_data (core_data[k])
    );
  end

  // Finished flags are sticky, so done stays high until reset.
  always_ff @(posedge clock) begin
    if (reset) done <= 1'b0;
    else       done <= &finished;
  end

  logic [ADDR_W-1:0] col_q, row_q, row_base_q;
  logic at_last;

  assign at_last    = (row_q == ADDR_W'(NUM_ROWS - 1)) && (col_q == ADDR_W'(NUM_COLUMNS - 1));
  assign end_stream = done && at_last;

  always_ff @(posedge clock) begin
    if (reset) begin
      col_q        <= '0;
      row_q        <= '0;
      row_base_q   <= '0;
      rd_solver_id <= '0;
      rd_addr      <= '0;
    end else if (done && !at_last) begin
      if (col_q == ADDR_W'(NUM_COLUMNS - 1)) begin
        // Row wrap jumps to the next row's base, skipping unused slots.
        col_q        <= '0;
        row_q        <= row_q + 1'b1;
        row_base_q   <= row_base_q + ADDR_W'(CPS);
        rd_solver_id <= '0;
        rd_addr      <= row_base_q + ADDR_W'(CPS);
      end else begin
        col_q <= col_q + 1'b1;
        if (rd_solver_id == ID_W'(NUM_SOLVERS - 1)) begin
          rd_solver_id <= '0;
          rd_addr      <= rd_addr + 1'b1;
        end else begin
          rd_solver_id <= rd_solver_id + 1'b1;
        end
      end
    end
  end

  // Core RAM outputs lag the address by one cycle, so the mux select is
  // delayed to match; the output register adds the second cycle.
  logic [ID_W-1:0]  rd_sel_q;
  logic [CNT_W-1:0] sel_data;

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_SOLVERS; k++) begin
      if (rd_sel_q == ID_W'(k)) sel_data = core_data[k];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_sel_q    <= '0;
      rd_data_out <= '0;
    end else begin
      rd_sel_q    <= rd_solver_id;
      rd_data_out <= sel_data;
    end
  end

endmodule

// File: tb/tb_fractal_engine.sv
// tb/tb_fractal_engine.sv - self-checking bench for fractal_engine
module tb_fractal_engine;

  logic clk;
  logic [2:0] rst;
  logic [26:0] min_x, min_y, dx, dy;

  logic        done1, done7, done3;
  logic [5:0]  id1, id7, id3;
  logic [18:0] addr1, addr7, addr3;
  logic [7:0]  data1, data7, data3;
  logic        end1, end7, end3;

  fractal_engine #(.NUM_SOLVERS(1), .NUM_COLUMNS(1), .NUM_ROWS(1), .MAX_ITER(255)) u1 (
    .clock(clk), .reset(rst[0]), .min_x(min_x), .min_y(min_y), .dx(dx), .dy(dy),
    .done(done1), .rd_solver_id(id1), .rd_addr(addr1), .rd_data_out(data1), .end_stream(end1));

  fractal_engine #(.NUM_SOLVERS(7), .NUM_COLUMNS(99), .NUM_ROWS(66), .MAX_ITER(32)) u7 (
    .clock(clk), .reset(rst[1]), .min_x(min_x), .min_y(min_y), .dx(dx), .dy(dy),
    .done(done7), .rd_solver_id(id7), .rd_addr(addr7), .rd_data_out(data7), .end_stream(end7));

  fractal_engine #(.NUM_SOLVERS(3), .NUM_COLUMNS(8), .NUM_ROWS(5), .MAX_ITER(255)) u3 (
    .clock(clk), .reset(rst[2]), .min_x(min_x), .min_y(min_y), .dx(dx), .dy(dy),
    .done(done3), .rd_solver_id(id3), .rd_addr(addr3), .rd_data_out(data3), .end_stream(end3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int sel;
  logic obs_done, obs_end;
  logic [5:0]  obs_id;
  logic [18:0] obs_addr;
  logic [7:0]  obs_data;

  always_comb begin
    obs_done = 1'b0; obs_end = 1'b0; obs_id = '0; obs_addr = '0; obs_data = '0;
    case (sel)
      0: begin obs_done = done1; obs_end = end1; obs_id = id1; obs_addr = addr1; obs_data = data1; end
      1: begin obs_done = done7; obs_end = end7; obs_id = id7; obs_addr = addr7; obs_data = data7; end
      default: begin obs_done = done3; obs_end = end3; obs_id = id3; obs_addr = addr3; obs_data = data3; end
    endcase
  end

  int n_checks = 0;
  int n_fail = 0;
  int exp_q[$];

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain integer arithmetic on Q4.23 values.
  function automatic longint sx27(input longint v);
    longint t;
    t = v & 64'h7FFFFFF;
    if (t >= 64'h4000000) t = t - 64'h8000000;
    return t;
  endfunction

  function automatic longint trunc_q(input longint p);
    return sx27(p >>> 23);
  endfunction

  function automatic int mandel(input longint cx, input longint cy, input int max_iter);
    longint zx, zy, nzx;
    zx = 0; zy = 0;
    for (int n = 0; n < max_iter; n++) begin
      if (zx * zx + zy * zy > (longint'(4) << 46)) return n;
      nzx = sx27(trunc_q(zx * zx) - trunc_q(zy * zy) + cx);
      zy  = sx27(2 * trunc_q(zx * zy) + cy);
      zx  = nzx;
    end
    return max_iter;
  endfunction

  task automatic build_frame(input logic [26:0] mx, my, sx, sy, input int cols, rows, max_iter);
    exp_q.delete();
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++)
        exp_q.push_back(mandel(sx27(longint'(mx) + longint'(c) * longint'(sx)),
                               sx27(longint'(my) + longint'(r) * longint'(sy)), max_iter));
  endtask

  task automatic start(input int which, input logic [26:0] mx, my, sx, sy);
    min_x = mx; min_y = my; dx = sx; dy = sy;
    rst = 3'b111;
    tick;
    tick;
    rst[which] = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!obs_done && cycles < 40000) begin
      tick;
      cycles++;
    end
    check("done_within_budget", obs_done, 1);
  endtask

  // Called on the first cycle with done=1; checks addresses, end_stream and
  // data (two cycles behind) for the first 'limit' pixels.
  task automatic readout(input int n, cols, rows, cps, limit);
    int total, span, r, c;
    total = cols * rows;
    span = ((limit < total) ? limit : total) + 2;
    for (int i = 0; i < span; i++) begin
      if (i < limit && i < total) begin
        r = i / cols;
        c = i % cols;
        check("rd_solver_id", obs_id, c % n);
        check("rd_addr", obs_addr, r * cps + c / n);
        check("end_stream", obs_end, (i == total - 1) ? 1 : 0);
        check("slot_in_frame", ((obs_addr % cps) * n + obs_id < cols) ? 1 : 0, 1);
        if (n == 7 && i == 98) begin
          check("r0c98_id", obs_id, 0);
          check("r0c98_addr", obs_addr, 14);
        end
        if (n == 7 && i == 99) begin
          check("r1c0_id", obs_id, 0);
          check("r1c0_addr", obs_addr, 15);
        end
      end else if (i >= total) begin
        check("end_stream_hold", obs_end, 1);
        check("id_hold", obs_id, (cols - 1) % n);
        check("addr_hold", obs_addr, (rows - 1) * cps + (cols - 1) / n);
      end
      if (i >= 2) check("rd_data_out", obs_data, exp_q[i - 2]);
      tick;
    end
  endtask

  initial begin
    int k;
    logic [26:0] rx, ry, rdx, rdy;

    sel = 1;
    rst = 3'b111;
    min_x = '0; min_y = '0; dx = '0; dy = '0;
    tick; tick; tick;
    check("reset_done", obs_done, 0);
    check("reset_id", obs_id, 0);
    check("reset_addr", obs_addr, 0);
    check("reset_end", obs_end, 0);
    check("reset_data", obs_data, 0);

    // 1x1 frame at the origin: never escapes.
    sel = 0;
    build_frame(27'd0, 27'd0, 27'd0, 27'd0, 1, 1, 255);
    start(0, 27'd0, 27'd0, 27'd0, 27'd0);
    wait_done(k);
    readout(1, 1, 1, 1, 1);
    check("origin_count", obs_data, 255);

    // c = 2+2i escapes after one iteration; done three cycles after release.
    build_frame(27'h1000000, 27'h1000000, 27'd0, 27'd0, 1, 1, 255);
    start(0, 27'h1000000, 27'h1000000, 27'd0, 27'd0);
    wait_done(k);
    check("done_latency", k, 3);
    readout(1, 1, 1, 1, 1);
    check("escape_count", obs_data, 1);

    // c = -2: |z|^2 sits exactly at 4 and must not count as escaped.
    build_frame(27'h7000000, 27'd0, 27'd0, 27'd0, 1, 1, 255);
    start(0, 27'h7000000, 27'd0, 27'd0, 27'd0);
    wait_done(k);
    readout(1, 1, 1, 1, 1);
    check("boundary_count", obs_data, 255);

    // Full 99x66 frame on seven cores, reset part way through readout.
    sel = 1;
    build_frame(27'h7000000, 27'h7800000, 27'd254200, 27'd254200, 99, 66, 32);
    start(1, 27'h7000000, 27'h7800000, 27'd254200, 27'd254200);
    wait_done(k);
    readout(7, 99, 66, 15, 3000);
    rst[1] = 1'b1;
    tick;
    check("midreset_done", obs_done, 0);
    check("midreset_id", obs_id, 0);
    check("midreset_addr", obs_addr, 0);
    check("midreset_end", obs_end, 0);
    check("midreset_data", obs_data, 0);
    rst[1] = 1'b0;
    wait_done(k);
    readout(7, 99, 66, 15, 99 * 66);

    // Random windows on the 3-core 8-column frame with skipped slots.
    sel = 2;
    for (int f = 0; f < 4; f++) begin
      if (f == 0) begin
        rx = 27'($urandom); ry = 27'($urandom); rdx = 27'($urandom); rdy = 27'($urandom);
      end else begin
        rx  = 27'(-20971520 + int'($urandom_range(0, 16777216)));
        ry  = 27'(-12582912 + int'($urandom_range(0, 12582912)));
        rdx = 27'($urandom_range(0, 4194304));
        rdy = 27'($urandom_range(0, 4194304));
      end
      build_frame(rx, ry, rdx, rdy, 8, 5, 255);
      start(2, rx, ry, rdx, rdy);
      wait_done(k);
      readout(3, 8, 5, 3, 40);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
